alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
// - Execution stage directly downstream of the reservation station.
// - Takes one ready instruction per cycle (op, ic, qd, vs, vt, imm, pc).
// - Computes the ALU, branch or jump result and holds it in an output register until the CDB arbiter grants it.
// - Backpressures the reservation station with rdy_o; the reservation station issues only while rdy_o=1.
// PARAMETERS
// - DAT_W     `DAT_W (32)      operand/result width
// - ROB_BIT   `ROB_BIT (4)     ROB tag width; tag 0 reserved as "no tag"
// - OP_W      `OP_W            opcode width (encodings in utils/head.v)
// - ADR_W     `RAM_ADR_W (32)  pc/target width
// - MUL_CYC   32               iterative multiply latency in cycles (ALU_MUL_EN only)
// PORTS
// - clk      in   1         clock, rising edge
// - rst      in   1         reset, asynchronous, active-low
// - br_flag  in   1         mispredict flush, synchronous, highest priority after rst
// - en_i     in   1         issue valid from RS
// - op_i     in   OP_W      opcode
// - ic_i     in   1         0: second operand = imm_i; 1: second operand = vt_i
// - qd_i     in   ROB_BIT   destination ROB tag (never 0)
// - vs_i     in   DAT_W     rs1 value
// - vt_i     in   DAT_W     rs2 value
// - imm_i    in   DAT_W     sign-extended immediate
// - pc_i     in   ADR_W     instruction pc
// - rdy_o    out  1         unit can accept en_i this cycle
// - cdb_en_o out  1         result valid
// - cdb_q_o  out  ROB_BIT   result tag
// - cdb_v_o  out  DAT_W     result value (rd write data)
// - jmp_o    out  1         control transfer taken (branch taken or JAL/JALR)
// - tgt_o    out  ADR_W     taken target
// - cdb_gnt_i in  1         arbiter accepts the current result this cycle
// BEHAVIOUR
// - States: IDLE, MUL (ALU_MUL_EN only), DONE.
// - rst low (async): state IDLE, cdb_en_o/jmp_o/cdb_q_o/cdb_v_o/tgt_o = 0; rdy_o = 1 once out of reset.
// - rdy_o = (state==IDLE) | (state==DONE & cdb_gnt_i); combinational. Issue is accepted when en_i & rdy_o.
// - Single-cycle op accepted at edge T: result registered at T, cdb_en_o=1 during cycle T+1.
//   - Transitions: IDLE->DONE, or DONE->DONE when back-to-back with grant.
// - DONE holds all outputs stable until a cycle with cdb_gnt_i=1.
//   - At that edge: go IDLE (cdb_en_o=0), or load the new result if an issue was accepted in the same cycle.
// - cdb_gnt_i ignored when cdb_en_o=0.
// - Arithmetic (b = ic ? vt : imm):
//   - ADD/SUB/XOR/OR/AND: mod 2^DAT_W.
//   - SLT signed, SLTU unsigned, result 0/1.
//   - SLL/SRL/SRA: shift amount b[4:0]; SRA sign-fills.
// - LUI: v=imm. AUIPC: v=pc+imm.
// - JAL: v=pc+4, jmp=1, tgt=pc+imm. JALR: v=pc+4, jmp=1, tgt=(vs+imm)&~1.
// - BEQ/BNE/BLT/BGE/BLTU/BGEU: v=0, jmp=condition(vs,vt), tgt=pc+imm; when not taken tgt=pc+4.
// - Unknown op: v=0, jmp=0, still broadcast so the ROB entry retires.
// - br_flag=1: next state IDLE, cdb_en_o=0, any multiply abandoned.
//   - en_i in the same cycle is dropped.
//   - br_flag has priority over cdb_gnt_i.
// - qd=0 is never broadcast; a bench issue with qd_i=0 is illegal.
// CONFIGURATION
// - Macro ALU_MUL_EN defined:
//   - MUL/MULH/MULHSU/MULHU are accepted: IDLE->MUL, rdy_o=0.
//   - Shift-add runs for MUL_CYC cycles, then DONE.
//   - Accepted at T: cdb_en_o first high in cycle T+1+MUL_CYC.
//   - Signedness per RV32M.
// - Macro ALU_MUL_EN undefined: MUL* opcodes take the unknown-op path (v=0, single cycle). No MUL state, no multiplier logic.
// STRUCTURE
// - utils/head.v: opcode `defines (incl. MUL*), DAT_W/ROB_BIT/OP_W/RAM_ADR_W, the ALU_MUL_EN switch.
// - alu_mul_iter: sub-module, instantiated only under ALU_MUL_EN.
//   - Ports: start, a, b, signed_a, signed_b, hi_sel -> busy, done, product[DAT_W-1:0].
//   - Cleared by rst and br_flag.
// - State/result registers plus the combinational datapath stay in alu_unit.
// TESTING
// - Reset: rst=0 mid-DONE -> outputs 0 immediately; after release rdy_o=1, cdb_en_o=0.
// - ADD, ic=0, vs=5, imm=-7, qd=3, gnt held 1 -> next cycle cdb_en_o=1, q=3, v=0xFFFFFFFE.
//   - Back-to-back SRA vs=0x80000000, vt=4 -> v=0xF8000000 the following cycle.
// - BLT vs=-1, vt=1, pc=0x100, imm=0x20 -> jmp=1, tgt=0x120, v=0.
//   - JALR vs=0x203, imm=0 -> v=pc+4, tgt=0x202.
// - Backpressure: gnt=0 for 3 cycles -> cdb_en_o/v/q stable, rdy_o=0.
//   - gnt=1 with new en_i -> new result next cycle, no bubble.
// - Flush: br_flag=1 while DONE and en_i=1 -> cdb_en_o=0 next cycle, issued op lost, rdy_o=1.
// - ALU_MUL_EN: MULH vs=-2, vt=3 -> rdy_o=0 for MUL_CYC cycles, v=0xFFFFFFFF.
//   - br_flag mid-multiply -> IDLE, no broadcast.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared widths, opcode encodings and FSM states for the alu_unit execution stage.
// Optional iterative multiplier is enabled by defining ALU_MUL_EN.
package alu_unit_pkg;

  localparam int DAT_W   = 32;
  localparam int ROB_BIT = 4;
  localparam int OP_W    = 5;
  // pc and data share one width: link values (pc+4) land directly on the result bus
  localparam int ADR_W   = 32;
  localparam int MUL_CYC = DAT_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_LUI    = 5'd10,
    OP_AUIPC  = 5'd11,
    OP_JAL    = 5'd12,
    OP_JALR   = 5'd13,
    OP_BEQ    = 5'd14,
    OP_BNE    = 5'd15,
    OP_BLT    = 5'd16,
    OP_BGE    = 5'd17,
    OP_BLTU   = 5'd18,
    OP_BGEU   = 5'd19,
    OP_MUL    = 5'd20,
    OP_MULH   = 5'd21,
    OP_MULHSU = 5'd22,
    OP_MULHU  = 5'd23
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MUL_EN
    ,
    S_MUL  = 2'd2
`endif
  } state_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Issue bus from the reservation station and result bus toward the CDB arbiter.
interface alu_unit_if;
  import alu_unit_pkg::*;

  logic               en_i;
  logic [OP_W-1:0]    op_i;
  logic               ic_i;
  logic [ROB_BIT-1:0] qd_i;
  logic [DAT_W-1:0]   vs_i;
  logic [DAT_W-1:0]   vt_i;
  logic [DAT_W-1:0]   imm_i;
  logic [ADR_W-1:0]   pc_i;
  logic               rdy_o;
  logic               cdb_en_o;
  logic [ROB_BIT-1:0] cdb_q_o;
  logic [DAT_W-1:0]   cdb_v_o;
  logic               jmp_o;
  logic [ADR_W-1:0]   tgt_o;
  logic               cdb_gnt_i;

  modport master (
    output en_i, op_i, ic_i, qd_i, vs_i, vt_i, imm_i, pc_i, cdb_gnt_i,
    input  rdy_o, cdb_en_o, cdb_q_o, cdb_v_o, jmp_o, tgt_o
  );

  modport slave (
    input  en_i, op_i, ic_i, qd_i, vs_i, vt_i, imm_i, pc_i, cdb_gnt_i,
    output rdy_o, cdb_en_o, cdb_q_o, cdb_v_o, jmp_o, tgt_o
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier (one partial product per cycle), used when ALU_MUL_EN is defined.
// Works on operand magnitudes and restores the sign of the full 2*DAT_W product at the end.
module alu_mul_iter
  import alu_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [DAT_W-1:0] a,
  input  logic [DAT_W-1:0] b,
  input  logic             signed_a,
  input  logic             signed_b,
  input  logic             hi_sel,
  output logic             busy,
  output logic             done,
  output logic [DAT_W-1:0] product
);

  localparam int CNT_W = $clog2(MUL_CYC);

  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*DAT_W-1:0] r_acc;
  logic [2*DAT_W-1:0] r_mcand;
  logic [DAT_W-1:0]   r_mplier;
  logic               r_neg;
  logic               r_hi;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [DAT_W-1:0]   w_a_mag;
  logic [DAT_W-1:0]   w_b_mag;
  logic [2*DAT_W-1:0] w_acc_nxt;
  logic [2*DAT_W-1:0] w_res;

  assign w_a_neg = signed_a & a[DAT_W-1];
  assign w_b_neg = signed_b & b[DAT_W-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // The last partial product is folded in combinationally so the result is ready on the final count.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_res     = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_W'(MUL_CYC - 1));
  assign product = r_hi ? w_res[2*DAT_W-1:DAT_W] : w_res[DAT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
    end else if (flush) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{DAT_W{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_hi     <= hi_sel;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Execution stage: computes ALU/branch/jump results and holds them until the CDB arbiter grants.
// Define ALU_MUL_EN to add the RV32M multiply ops through the iterative alu_mul_iter sub-module.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     br_flag,
  alu_unit_if.slave io_bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_accept_state;
  logic               w_accept;

  logic [ROB_BIT-1:0] r_cdb_q;
  logic [DAT_W-1:0]   r_cdb_v;
  logic               r_jmp;
  logic [ADR_W-1:0]   r_tgt;

  logic [DAT_W-1:0]   w_b;
  logic [ADR_W-1:0]   w_pc_imm;
  logic [ADR_W-1:0]   w_pc4;
  logic [ADR_W-1:0]   w_jalr_sum;
  logic [DAT_W-1:0]   w_res_v;
  logic               w_res_jmp;
  logic [ADR_W-1:0]   w_res_tgt;
  logic               w_br_taken;
  logic               w_is_branch;

  assign io_bus.rdy_o    = (r_state == S_IDLE) || ((r_state == S_DONE) && io_bus.cdb_gnt_i);
  assign io_bus.cdb_en_o = (r_state == S_DONE);
  assign io_bus.cdb_q_o  = r_cdb_q;
  assign io_bus.cdb_v_o  = r_cdb_v;
  assign io_bus.jmp_o    = r_jmp;
  assign io_bus.tgt_o    = r_tgt;

  // A flush drops any issue presented in the same cycle.
  assign w_accept = io_bus.en_i && io_bus.rdy_o && !br_flag;

`ifdef ALU_MUL_EN
  logic             w_is_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic             w_mul_load;
  logic [DAT_W-1:0] w_mul_product;

  assign w_is_mul       = is_mul_op(io_bus.op_i);
  assign w_accept_state = w_is_mul ? S_MUL : S_DONE;
  assign w_mul_load     = (r_state == S_MUL) && w_mul_done && !br_flag;

  alu_mul_iter u_mul (
    .clk      (clk),
    .rst      (rst),
    .flush    (br_flag),
    .start    (w_accept && w_is_mul),
    .a        (io_bus.vs_i),
    .b        (io_bus.vt_i),
    .signed_a ((io_bus.op_i == OP_MULH) || (io_bus.op_i == OP_MULHSU)),
    .signed_b (io_bus.op_i == OP_MULH),
    .hi_sel   (io_bus.op_i != OP_MUL),
    .busy     (w_mul_busy),
    .done     (w_mul_done),
    .product  (w_mul_product)
  );
`else
  assign w_accept_state = S_DONE;
`endif

  assign w_b        = io_bus.ic_i ? io_bus.vt_i : io_bus.imm_i;
  assign w_pc_imm   = io_bus.pc_i + io_bus.imm_i;
  assign w_pc4      = io_bus.pc_i + ADR_W'(4);
  assign w_jalr_sum = io_bus.vs_i + io_bus.imm_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_res_v     = '0;
    w_res_jmp   = 1'b0;
    w_res_tgt   = '0;
    w_br_taken  = 1'b0;
    w_is_branch = 1'b0;
    case (io_bus.op_i)
      OP_ADD:   w_res_v = io_bus.vs_i + w_b;
      OP_SUB:   w_res_v = io_bus.vs_i - w_b;
      OP_XOR:   w_res_v = io_bus.vs_i ^ w_b;
      OP_OR:    w_res_v = io_bus.vs_i | w_b;
      OP_AND:   w_res_v = io_bus.vs_i & w_b;
      OP_SLT:   w_res_v = {{(DAT_W-1){1'b0}}, ($signed(io_bus.vs_i) < $signed(w_b))};
      OP_SLTU:  w_res_v = {{(DAT_W-1){1'b0}}, (io_bus.vs_i < w_b)};
      OP_SLL:   w_res_v = io_bus.vs_i << w_b[4:0];
      OP_SRL:   w_res_v = io_bus.vs_i >> w_b[4:0];
      OP_SRA:   w_res_v = $signed(io_bus.vs_i) >>> w_b[4:0];
      OP_LUI:   w_res_v = io_bus.imm_i;
      OP_AUIPC: w_res_v = w_pc_imm;
      OP_JAL: begin
        w_res_v   = w_pc4;
        w_res_jmp = 1'b1;
        w_res_tgt = w_pc_imm;
      end
      OP_JALR: begin
        w_res_v   = w_pc4;
        w_res_jmp = 1'b1;
        w_res_tgt = {w_jalr_sum[ADR_W-1:1], 1'b0};
      end
      OP_BEQ:  begin w_is_branch = 1'b1; w_br_taken = (io_bus.vs_i == io_bus.vt_i); end
      OP_BNE:  begin w_is_branch = 1'b1; w_br_taken = (io_bus.vs_i != io_bus.vt_i); end
      OP_BLT:  begin w_is_branch = 1'b1; w_br_taken = ($signed(io_bus.vs_i) <  $signed(io_bus.vt_i)); end
      OP_BGE:  begin w_is_branch = 1'b1; w_br_taken = ($signed(io_bus.vs_i) >= $signed(io_bus.vt_i)); end
      OP_BLTU: begin w_is_branch = 1'b1; w_br_taken = (io_bus.vs_i <  io_bus.vt_i); end
      OP_BGEU: begin w_is_branch = 1'b1; w_br_taken = (io_bus.vs_i >= io_bus.vt_i); end
      default: w_res_v = '0;
    endcase
    if (w_is_branch) begin
      w_res_jmp = w_br_taken;
      w_res_tgt = w_br_taken ? w_pc_imm : w_pc4;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (br_flag) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept)
            w_state_nxt = w_accept_state;
          else if ((r_state == S_DONE) && io_bus.cdb_gnt_i)
            w_state_nxt = S_IDLE;
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          if (w_mul_done)
            w_state_nxt = S_DONE;
          else if (!w_mul_busy)
            w_state_nxt = S_IDLE;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdb_q <= '0;
      r_cdb_v <= '0;
      r_jmp   <= 1'b0;
      r_tgt   <= '0;
    end else if (w_accept) begin
      r_cdb_q <= io_bus.qd_i;
      r_cdb_v <= w_res_v;
      r_jmp   <= w_res_jmp;
      r_tgt   <= w_res_tgt;
    end
`ifdef ALU_MUL_EN
    else if (w_mul_load) begin
      r_cdb_v <= w_mul_product;
    end
`endif
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: vector table with back-to-back grants, plus backpressure, flush,
// reset and (when ALU_MUL_EN is defined) multiply sequences.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic br_flag = 1'b0;

  alu_unit_if bus ();

  alu_unit dut (
    .clk     (clk),
    .rst     (rst),
    .br_flag (br_flag),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [OP_W-1:0]    op;
    logic               ic;
    logic [ROB_BIT-1:0] qd;
    logic [31:0]        vs;
    logic [31:0]        vt;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic [31:0]        v;
    logic               jmp;
    logic [31:0]        tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [OP_W-1:0] op, input logic ic, input logic [ROB_BIT-1:0] qd,
                              input logic [31:0] vs, input logic [31:0] vt, input logic [31:0] imm,
                              input logic [31:0] v, input logic jmp, input logic [31:0] tgt);
    vec_t r;
    r.op = op; r.ic = ic; r.qd = qd; r.vs = vs; r.vt = vt; r.imm = imm;
    r.pc = 32'h100; r.v = v; r.jmp = jmp; r.tgt = tgt;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    bus.en_i  = 1'b1;
    bus.op_i  = t.op;
    bus.ic_i  = t.ic;
    bus.qd_i  = t.qd;
    bus.vs_i  = t.vs;
    bus.vt_i  = t.vt;
    bus.imm_i = t.imm;
    bus.pc_i  = t.pc;
  endtask

  task automatic check_result(input vec_t t, input string tag);
    check({tag, ".cdb_en"}, 64'(bus.cdb_en_o), 64'd1);
    check({tag, ".q"},      64'(bus.cdb_q_o),  64'(t.qd));
    check({tag, ".v"},      64'(bus.cdb_v_o),  64'(t.v));
    check({tag, ".jmp"},    64'(bus.jmp_o),    64'(t.jmp));
    check({tag, ".tgt"},    64'(bus.tgt_o),    64'(t.tgt));
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input logic [OP_W-1:0] op, input logic [31:0] vs, input logic [31:0] vt,
                         input logic [ROB_BIT-1:0] qd, input logic [31:0] exp_v, input string tag);
    int busy_cyc;
    bit seen;
    busy_cyc = 0;
    seen     = 1'b0;
    @(negedge clk);
    bus.cdb_gnt_i = 1'b1;
    drive(mk(op, 1'b1, qd, vs, vt, 32'h0, 32'h0, 1'b0, 32'h0));
    #1 check({tag, ".rdy_pre"}, 64'(bus.rdy_o), 64'd1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.en_i = 1'b0;
      if (bus.cdb_en_o) begin
        seen = 1'b1;
        break;
      end
      if (!bus.rdy_o) busy_cyc++;
    end
    check({tag, ".seen"},     64'(seen),          64'd1);
    check({tag, ".busy_cyc"}, 64'(busy_cyc),      64'(MUL_CYC));
    check({tag, ".q"},        64'(bus.cdb_q_o),   64'(qd));
    check({tag, ".v"},        64'(bus.cdb_v_o),   64'(exp_v));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en_i = 1'b0; bus.op_i = '0; bus.ic_i = 1'b0; bus.qd_i = '0;
    bus.vs_i = '0; bus.vt_i = '0; bus.imm_i = '0; bus.pc_i = '0;
    bus.cdb_gnt_i = 1'b0;

    vecs.push_back(mk(OP_ADD,   1'b0, 4'd3,  32'd5,        32'd0,        32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SRA,   1'b1, 4'd4,  32'h80000000, 32'd4,        32'h0,        32'hF8000000, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SUB,   1'b1, 4'd5,  32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 1'b0, 32'h0));
    vecs.push_back(mk(OP_XOR,   1'b0, 4'd6,  32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 32'hFF00FF00, 1'b0, 32'h0));
    vecs.push_back(mk(OP_OR,    1'b1, 4'd7,  32'h00FF0000, 32'h0000FF00, 32'h0,        32'h00FFFF00, 1'b0, 32'h0));
    vecs.push_back(mk(OP_AND,   1'b0, 4'd8,  32'h12345678, 32'h0,        32'h0000FFFF, 32'h00005678, 1'b0, 32'h0));
    vecs.push_back(mk(OP_SLT,   1'b1, 4'd9,  32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        1'b0, 32'h0));
    vecs.push_back(mk(OP_SLTU,  1'b1, 4'd10, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        1'b0, 32'h0));
    vecs.push_back(mk(OP_SLL,   1'b0, 4'd11, 32'd1,        32'h0,        32'h25,       32'h20,       1'b0, 32'h0));
    vecs.push_back(mk(OP_SRL,   1'b1, 4'd12, 32'h80000000, 32'd31,       32'h0,        32'd1,        1'b0, 32'h0));
    vecs.push_back(mk(OP_SRA,   1'b1, 4'd13, 32'h7FFFFFFF, 32'd31,       32'h0,        32'd0,        1'b0, 32'h0));
    vecs.push_back(mk(OP_LUI,   1'b0, 4'd14, 32'hDEAD,     32'h0,        32'h12345000, 32'h12345000, 1'b0, 32'h0));
    vecs.push_back(mk(OP_AUIPC, 1'b0, 4'd15, 32'h0,        32'h0,        32'h1000,     32'h1100,     1'b0, 32'h0));
    vecs.push_back(mk(OP_JAL,   1'b0, 4'd1,  32'h0,        32'h0,        32'h40,       32'h104,      1'b1, 32'h140));
    vecs.push_back(mk(OP_JALR,  1'b0, 4'd2,  32'h203,      32'h0,        32'h0,        32'h104,      1'b1, 32'h202));
    vecs.push_back(mk(OP_BLT,   1'b1, 4'd3,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        1'b1, 32'h120));
    vecs.push_back(mk(OP_BEQ,   1'b1, 4'd4,  32'd5,        32'd6,        32'h20,       32'h0,        1'b0, 32'h104));
    vecs.push_back(mk(OP_BEQ,   1'b1, 4'd5,  32'd7,        32'd7,        32'h20,       32'h0,        1'b1, 32'h120));
    vecs.push_back(mk(OP_BNE,   1'b1, 4'd6,  32'd5,        32'd6,        32'h20,       32'h0,        1'b1, 32'h120));
    vecs.push_back(mk(OP_BGE,   1'b1, 4'd7,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        1'b0, 32'h104));
    vecs.push_back(mk(OP_BGE,   1'b1, 4'd8,  32'd1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h0,        1'b1, 32'hF0));
    vecs.push_back(mk(OP_BLTU,  1'b1, 4'd9,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        1'b0, 32'h104));
    vecs.push_back(mk(OP_BGEU,  1'b1, 4'd10, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        1'b1, 32'h120));
    vecs.push_back(mk(OP_ADD,   1'b1, 4'd11, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(5'd31,    1'b1, 4'd12, 32'd9,        32'd9,        32'h20,       32'h0,        1'b0, 32'h0));
`ifndef ALU_MUL_EN
    vecs.push_back(mk(OP_MULH,  1'b1, 4'd13, 32'd7,        32'd3,        32'h0,        32'h0,        1'b0, 32'h0));
`endif

    // Reset state
    #12;
    check("rst.cdb_en", 64'(bus.cdb_en_o), 64'd0);
    check("rst.q",      64'(bus.cdb_q_o),  64'd0);
    check("rst.v",      64'(bus.cdb_v_o),  64'd0);
    check("rst.jmp",    64'(bus.jmp_o),    64'd0);
    check("rst.tgt",    64'(bus.tgt_o),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rel.rdy",    64'(bus.rdy_o),    64'd1);
    check("rst_rel.cdb_en", 64'(bus.cdb_en_o), 64'd0);

    // Back-to-back table with grant held high
    bus.cdb_gnt_i = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) check_result(vecs[i-1], $sformatf("vec%0d", i - 1));
      drive(vecs[i]);
      #1 check($sformatf("vec%0d.rdy", i), 64'(bus.rdy_o), 64'd1);
    end
    @(negedge clk);
    check_result(vecs[vecs.size()-1], $sformatf("vec%0d", vecs.size() - 1));
    bus.en_i = 1'b0;
    @(negedge clk);
    check("drain.cdb_en", 64'(bus.cdb_en_o), 64'd0);

    // Backpressure: result held for three ungranted cycles
    bus.cdb_gnt_i = 1'b0;
    drive(mk(OP_ADD, 1'b1, 4'd7, 32'd100, 32'd23, 32'h0, 32'd123, 1'b0, 32'h0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.en_i = 1'b0;
      #1;
      check($sformatf("bp%0d.cdb_en", k), 64'(bus.cdb_en_o), 64'd1);
      check($sformatf("bp%0d.q", k),      64'(bus.cdb_q_o),  64'd7);
      check($sformatf("bp%0d.v", k),      64'(bus.cdb_v_o),  64'd123);
      check($sformatf("bp%0d.rdy", k),    64'(bus.rdy_o),    64'd0);
    end
    @(negedge clk);
    check("bp_last.v", 64'(bus.cdb_v_o), 64'd123);
    bus.cdb_gnt_i = 1'b1;
    drive(mk(OP_XOR, 1'b0, 4'd9, 32'hFF, 32'h0, 32'h0F, 32'hF0, 1'b0, 32'h0));
    #1 check("bp_gnt.rdy", 64'(bus.rdy_o), 64'd1);
    @(negedge clk);
    check("bp_next.cdb_en", 64'(bus.cdb_en_o), 64'd1);
    check("bp_next.q",      64'(bus.cdb_q_o),  64'd9);
    check("bp_next.v",      64'(bus.cdb_v_o),  64'hF0);
    bus.cdb_gnt_i = 1'b0;
    bus.en_i      = 1'b0;

    // Flush while DONE with a concurrent issue and grant
    @(negedge clk);
    check("pre_flush.v", 64'(bus.cdb_v_o), 64'hF0);
    br_flag       = 1'b1;
    bus.cdb_gnt_i = 1'b1;
    drive(mk(OP_ADD, 1'b1, 4'd11, 32'd1, 32'd1, 32'h0, 32'd2, 1'b0, 32'h0));
    @(negedge clk);
    br_flag       = 1'b0;
    bus.en_i      = 1'b0;
    bus.cdb_gnt_i = 1'b0;
    #1;
    check("flush.cdb_en", 64'(bus.cdb_en_o), 64'd0);
    check("flush.rdy",    64'(bus.rdy_o),    64'd1);
    @(negedge clk);
    check("flush.op_lost", 64'(bus.cdb_en_o), 64'd0);

    // Asynchronous reset while holding a result
    drive(mk(OP_JAL, 1'b0, 4'd4, 32'h0, 32'h0, 32'h40, 32'h104, 1'b1, 32'h140));
    @(negedge clk);
    bus.en_i = 1'b0;
    check("pre_rst.cdb_en", 64'(bus.cdb_en_o), 64'd1);
    check("pre_rst.jmp",    64'(bus.jmp_o),    64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst.cdb_en", 64'(bus.cdb_en_o), 64'd0);
    check("arst.jmp",    64'(bus.jmp_o),    64'd0);
    check("arst.q",      64'(bus.cdb_q_o),  64'd0);
    check("arst.v",      64'(bus.cdb_v_o),  64'd0);
    check("arst.tgt",    64'(bus.tgt_o),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_rel.rdy",    64'(bus.rdy_o),    64'd1);
    check("arst_rel.cdb_en", 64'(bus.cdb_en_o), 64'd0);

`ifdef ALU_MUL_EN
    run_mul(OP_MULH,   32'hFFFFFFFE, 32'd3,        4'd5, 32'hFFFFFFFF, "mulh");
    run_mul(OP_MUL,    32'hFFFFFFFE, 32'd3,        4'd6, 32'hFFFFFFFA, "mul");
    run_mul(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        4'd7, 32'hFFFFFFFF, "mulhsu");
    run_mul(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 32'hFFFFFFFE, "mulhu");

    // Flush in the middle of a multiply
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      bus.cdb_gnt_i = 1'b1;
      drive(mk(OP_MULHU, 1'b1, 4'd9, 32'd1234, 32'd5678, 32'h0, 32'h0, 1'b0, 32'h0));
      repeat (10) begin
        @(negedge clk);
        bus.en_i = 1'b0;
      end
      check("mflush.rdy_busy", 64'(bus.rdy_o), 64'd0);
      br_flag = 1'b1;
      @(negedge clk);
      br_flag = 1'b0;
      #1;
      check("mflush.rdy",    64'(bus.rdy_o),    64'd1);
      check("mflush.cdb_en", 64'(bus.cdb_en_o), 64'd0);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (bus.cdb_en_o) seen = 1'b1;
      end
      check("mflush.no_bcast", 64'(seen), 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
